radix4_booth_seq_fsm: RTL and testbench
=======================================

# radix4_booth_seq_fsm

Control state machine for the sequential radix-4 Booth multiplier. It sits beside the Booth data path and sequences it: it loads operands on `start_booth`, gates iterations with `en_booth`, holds the iteration counter in reset through `rst_cntr_n`, and raises `done` (the multiplier's `ready`) when the data path's counter reports completion. It knows nothing about the operand width; iteration count is owned entirely by the data path via `done_cntr`.

## Interface
- Parameters: none.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset. Forces state IDLE immediately.
- `en` input 1: global enable. When 0, the FSM freezes its state and gates iteration outputs.
- `start` input 1: request a new multiplication. Sampled only when `en`=1.
- `done_cntr` input 1: data-path iteration counter has reached its final iteration.
- `start_booth` output 1: load operands into the data path this cycle.
- `en_booth` output 1: advance the data path and counter by one Booth iteration.
- `rst_cntr_n` output 1: active-low reset for the data-path iteration counter.
- `done` output 1: result valid. Level signal.

## Operation
- Moore machine with 4 states, encoded as 2 bits:
  - IDLE (reset state)
  - LOAD
  - RUN
  - DONE
- Outputs are decoded from state only and are gated by `en`:
  - IDLE: `start_booth`=0, `en_booth`=0, `rst_cntr_n`=0, `done`=0.
  - LOAD: `start_booth`=`en`, `en_booth`=`en`, `rst_cntr_n`=1, `done`=0.
  - RUN: `start_booth`=0, `en_booth`=`en`, `rst_cntr_n`=1, `done`=0.
  - DONE: `start_booth`=0, `en_booth`=0, `rst_cntr_n`=0, `done`=1.
- Transitions are evaluated only when `en`=1. When `en`=0, the state holds.
  - IDLE: `start` → LOAD, else stay.
  - LOAD: → RUN unconditionally.
  - RUN: `done_cntr` → DONE, else stay.
  - DONE: `start` → LOAD (back-to-back operation), else stay. `done` remains high until the next start.
- `start` is ignored in LOAD and RUN; there is no abort.
- `done_cntr` is ignored outside RUN.
- If the state register reaches an illegal encoding, the next state is IDLE.

## Timing
- Reset values: state IDLE, so `start_booth`=0, `en_booth`=0, `rst_cntr_n`=0, `done`=0. All outputs take these values asynchronously on `rst` assertion.
- `rst` asserted mid-operation aborts to IDLE; the counter is held reset from that point.
- Latency, counting from the edge that samples `start`=1 with `en`=1 (edge 0):
  - LOAD occupies cycle 1.
  - RUN occupies from cycle 2.
  - If `done_cntr` is first high in RUN at cycle k, `done` rises at cycle k+1.
- Each cycle of `en`=0 adds one cycle to this latency.
- DONE with `start`=1 goes to LOAD on the next edge, and `done` drops in that same cycle.
- All state changes happen on the rising edge of `clk`.

## Configuration
- `RADIX4_BOOTH_FSM_SVA_EN`: when defined, concurrent assertions are compiled in, all disabled while `rst` is high:
  - `done` implies `en_booth`=0.
  - `start_booth` implies `en_booth`.
  - `start_booth` is never high for two consecutive enabled cycles.
  - `done` rises only one cycle after `done_cntr` was high in RUN.
  - The state is always legal.
- When the macro is undefined, no assertion code is compiled and functional behaviour is identical.

## Test plan
- Reset: assert `rst` mid-RUN → all outputs return to 0/0/0/0 immediately (before the next clock edge); after release with `start`=0, the FSM stays IDLE.
- Basic op: `en`=1, pulse `start` for 1 cycle, drive `done_cntr` high on the 4th RUN cycle → `start_booth` high for 1 cycle, `en_booth` high for 5 cycles, `done`=1 from the following cycle and held.
- Stall: deassert `en` for 3 cycles in RUN → `en_booth`=0 and state frozen; `done` is delayed by exactly 3 cycles.
- Start ignored: pulse `start` during RUN → no second `start_booth`; completion timing unchanged.
- Back-to-back: `start`=1 while in DONE → LOAD next cycle, `done` falls, and a second full sequence completes.
- Spurious `done_cntr`: drive `done_cntr`=1 in IDLE and in LOAD → no effect; `done` stays 0.

Source files
------------

// File: rtl/radix4_booth_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : radix4_booth_seq_fsm
// Purpose  : Control FSM for a sequential radix-4 Booth multiplier. It loads
//            operands, steps the data path one Booth iteration per enabled
//            cycle, holds the data-path iteration counter in reset while
//            inactive, and flags the result as valid once the data path's
//            counter reports its final iteration. The operand width is not
//            known here; the data path owns the iteration count.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous active-high reset (state -> IDLE)
//            en           - global enable; 0 freezes state, gates iterations
//            start        - request a new multiplication (sampled when en=1)
//            done_cntr    - data-path counter reached its final iteration
//            start_booth  - load operands into the data path this cycle
//            en_booth     - advance data path and counter by one iteration
//            rst_cntr_n   - active-low reset for the data-path counter
//            done         - result valid (level, held until the next start)
// Options  : RADIX4_BOOTH_FSM_SVA_EN - compiles in concurrent assertions
// Revision : 1.0 - initial release
// ============================================================================
module radix4_booth_seq_fsm (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic done_cntr,
    output logic start_booth,
    output logic en_booth,
    output logic rst_cntr_n,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // State register; the asynchronous reset makes every output fall back
    // to its IDLE value without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore output decode. Outputs that move the data path
    // are additionally gated by en so a stalled cycle performs no iteration.
    always_comb begin
        w_state_next = r_state;
        start_booth  = 1'b0;
        en_booth     = 1'b0;
        rst_cntr_n   = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (en && start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                // The load cycle also counts as the first iteration enable,
                // so the counter advances together with the operand load.
                start_booth = en;
                en_booth    = en;
                rst_cntr_n  = 1'b1;
                if (en) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                en_booth   = en;
                rst_cntr_n = 1'b1;
                if (en && done_cntr) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (en && start) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef RADIX4_BOOTH_FSM_SVA_EN
    a_done_no_iter : assert property (@(posedge clk) disable iff (rst)
        done |-> !en_booth);

    a_load_implies_iter : assert property (@(posedge clk) disable iff (rst)
        start_booth |-> en_booth);

    a_single_load : assert property (@(posedge clk) disable iff (rst)
        start_booth |=> !start_booth);

    a_done_after_cntr : assert property (@(posedge clk) disable iff (rst)
        $rose(done) |-> $past(r_state == RUN && en && done_cntr));

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        r_state inside {IDLE, LOAD, RUN, DONE});
`endif

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix4_booth_seq_fsm
// Purpose  : Directed self-checking bench for radix4_booth_seq_fsm. Outputs
//            are compared as the vector {start_booth, en_booth, rst_cntr_n,
//            done} against hand-computed values one step after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix4_booth_seq_fsm;

    logic clk;
    logic rst;
    logic en;
    logic start;
    logic done_cntr;
    logic start_booth;
    logic en_booth;
    logic rst_cntr_n;
    logic done;

    int checks;
    int errors;

    logic [3:0] outs;
    assign outs = {start_booth, en_booth, rst_cntr_n, done};

    // Expected output vectors per state
    localparam logic [3:0] C_IDLE      = 4'b0000;
    localparam logic [3:0] C_LOAD      = 4'b1110;
    localparam logic [3:0] C_RUN       = 4'b0110;
    localparam logic [3:0] C_RUN_STALL = 4'b0010;
    localparam logic [3:0] C_LOAD_STALL= 4'b0010;
    localparam logic [3:0] C_DONE      = 4'b0001;

    radix4_booth_seq_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .done_cntr   (done_cntr),
        .start_booth (start_booth),
        .en_booth    (en_booth),
        .rst_cntr_n  (rst_cntr_n),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change, then compare.
    task automatic check(input string tag, input logic [3:0] expected);
        #1;
        checks++;
        assert (outs === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, outs, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en        = 1'b1;
        start     = 1'b0;
        done_cntr = 1'b0;

        // Reset state
        tick();
        check("reset_idle", C_IDLE);
        rst = 1'b0;
        tick();
        check("idle_after_release", C_IDLE);

        // Spurious done_cntr in IDLE
        done_cntr = 1'b1;
        tick();
        check("idle_spurious_cntr", C_IDLE);
        done_cntr = 1'b0;

        // Basic operation: start pulse, done_cntr on 4th RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_load", C_LOAD);
        tick();
        check("basic_run1", C_RUN);
        tick();
        check("basic_run2", C_RUN);
        tick();
        check("basic_run3", C_RUN);
        tick();
        done_cntr = 1'b1;
        check("basic_run4", C_RUN);
        tick();
        done_cntr = 1'b0;
        check("basic_done", C_DONE);
        tick();
        check("basic_done_held", C_DONE);

        // Enable low in DONE with start: state must hold
        en    = 1'b0;
        start = 1'b1;
        tick();
        check("done_frozen_en0", C_DONE);
        en    = 1'b1;

        // Back-to-back: start in DONE -> LOAD, done falls
        tick();
        start = 1'b0;
        done_cntr = 1'b1;   // spurious in LOAD: must not skip RUN
        check("b2b_load", C_LOAD);

        // Stall in LOAD gates start_booth/en_booth
        en = 1'b0;
        check("load_stall", C_LOAD_STALL);
        en = 1'b1;

        tick();
        done_cntr = 1'b0;
        check("b2b_run1", C_RUN);

        // start during RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", C_RUN);

        // Stall for 3 cycles in RUN; done_cntr ignored while frozen
        en        = 1'b0;
        done_cntr = 1'b1;
        check("stall_1", C_RUN_STALL);
        tick();
        check("stall_2", C_RUN_STALL);
        tick();
        check("stall_3", C_RUN_STALL);
        tick();
        en        = 1'b1;
        done_cntr = 1'b0;
        check("stall_resume_run3", C_RUN);
        tick();
        done_cntr = 1'b1;
        check("stall_run4", C_RUN);
        tick();
        done_cntr = 1'b0;
        check("b2b_done", C_DONE);

        // Asynchronous reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_test_load", C_LOAD);
        tick();
        check("rst_test_run", C_RUN);
        tick();
        rst = 1'b1;
        check("async_reset_midrun", C_IDLE);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_idle1", C_IDLE);
        tick();
        check("post_reset_idle2", C_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
